// File: rtl/tpu_readback_pkg.sv
// Shared types and constants for the UB readback path: state encoding, row/byte geometry, address fields.
package tpu_readback_pkg;

    localparam int ROW_BITS       = 256;
    localparam int BYTE_BITS      = 8;
    localparam int ROW_BYTES      = ROW_BITS / BYTE_BITS;
    localparam int BYTE_IDX_BITS  = $clog2(ROW_BYTES);
    localparam int BANK_BIT       = 8;
    localparam int ROW_FIELD_BITS = BANK_BIT;
    localparam int ADDR_BITS      = BANK_BIT + 1;
    localparam int RD_TIMEOUT     = 255;

    // One-hot so ub_rd_en can come straight off a single state flop.
    typedef enum logic [4:0] {
        IDLE = 5'b00001,
        REQ  = 5'b00010,
        WAIT = 5'b00100,
        SEND = 5'b01000,
        DONE = 5'b10000
    } rb_state_e;

    localparam int REQ_BIT = 1;

    typedef struct packed {
        logic                      bank;
        logic [ROW_FIELD_BITS-1:0] row;
    } ub_addr_t;

    // Row field wraps modulo 256; the bank bit is carried through untouched.
    function automatic ub_addr_t row_addr(input ub_addr_t base, input logic [ROW_FIELD_BITS-1:0] idx);
        row_addr.bank = base.bank;
        row_addr.row  = base.row + idx;
    endfunction

endpackage

// File: rtl/ub_readback_tx_if.sv
// UB single-row read request/response bus plus the byte stream toward the UART transmitter.
interface ub_readback_tx_if;
    import tpu_readback_pkg::*;

    logic                 ub_rd_en;
    ub_addr_t             ub_rd_addr;
    logic [ADDR_BITS-1:0] ub_rd_count;
    logic [ROW_BITS-1:0]  ub_rd_data;
    logic                 ub_rd_valid;

    logic [BYTE_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (
        output ub_rd_en, ub_rd_addr, ub_rd_count, tx_data, tx_valid,
        input  ub_rd_data, ub_rd_valid, tx_ready
    );

    modport slave (
        input  ub_rd_en, ub_rd_addr, ub_rd_count, tx_data, tx_valid,
        output ub_rd_data, ub_rd_valid, tx_ready
    );

endinterface

// File: rtl/row_byte_serializer.sv
// Holds one UB row and emits it LSB byte first; first byte valid the cycle after load, one byte per cycle.
// Byte and index hold while tx_ready is low; flush drops tx_valid next cycle without transferring.
module row_byte_serializer
    import tpu_readback_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [ROW_BITS-1:0]  load_dat,
    input  logic                 flush,
    output logic [BYTE_BITS-1:0] tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 last_byte
);

    logic [ROW_BITS-1:0]      row_q;
    logic [BYTE_IDX_BITS-1:0] byte_idx;
    logic                     fire;

    assign fire      = tx_valid && tx_ready;
    assign last_byte = (byte_idx == BYTE_IDX_BITS'(ROW_BYTES - 1));
    assign tx_data   = row_q[BYTE_BITS-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q    <= '0;
            byte_idx <= '0;
            tx_valid <= 1'b0;
        end else if (flush) begin
            byte_idx <= '0;
            tx_valid <= 1'b0;
        end else if (load) begin
            row_q    <= load_dat;
            byte_idx <= '0;
            tx_valid <= 1'b1;
        end else if (fire) begin
            // Shifting keeps the current byte in the low lane, so tx_data is a plain wire.
            row_q    <= row_q >> BYTE_BITS;
            byte_idx <= byte_idx + 1'b1;
            if (last_byte) begin
                tx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ub_readback_tx.sv
// Dumps row_count UB rows as a byte stream; ub_rd_en the cycle after start, bytes the cycle after each row lands.
// Stalls on tx_ready without changing tx_data; abort returns to IDLE next cycle, dropping any held byte.
module ub_readback_tx
    import tpu_readback_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] base_addr,
    input  logic [ADDR_BITS-1:0] row_count,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 err_timeout,
    ub_readback_tx_if.master     ub
);

    rb_state_e            state, state_nxt;
    ub_addr_t             base_q;
    logic [ADDR_BITS-1:0] count_q;
    logic [ADDR_BITS-1:0] row_idx;
    logic [7:0]           tmo_cnt;
    logic                 start_acc;
    logic                 capture;
    logic                 row_done;
    logic                 tmo_hit;
    logic                 last_byte;

    assign start_acc = (state == IDLE) && start;
    assign capture   = (state == WAIT) && ub.ub_rd_valid && !abort;
    assign row_done  = (state == SEND) && ub.tx_valid && ub.tx_ready && last_byte;
    assign tmo_hit   = (state == WAIT) && !ub.ub_rd_valid && (tmo_cnt == 8'(RD_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort && (state != IDLE)) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: if (start) state_nxt = (row_count == '0) ? DONE : REQ;
                REQ:  state_nxt = WAIT;
                WAIT: begin
                    if (ub.ub_rd_valid) begin
                        state_nxt = SEND;
                    end else if (tmo_hit) begin
                        state_nxt = DONE;
                    end
                end
                SEND: if (row_done) state_nxt = ((row_idx + 9'd1) == count_q) ? DONE : REQ;
                DONE: state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy           = 1'b0;
        done           = 1'b0;
        ub.ub_rd_addr  = '0;
        ub.ub_rd_count = '0;
        unique case (state)
            IDLE: busy = 1'b0;
            REQ: begin
                busy           = 1'b1;
                ub.ub_rd_addr  = row_addr(base_q, row_idx[ROW_FIELD_BITS-1:0]);
                ub.ub_rd_count = ADDR_BITS'(1);
            end
            WAIT, SEND: busy = 1'b1;
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

    // Taken directly from the REQ flop so reset or state changes cannot glitch the request.
    assign ub.ub_rd_en = state[REQ_BIT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q      <= '0;
            count_q     <= '0;
            row_idx     <= '0;
            tmo_cnt     <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (start_acc) begin
                base_q      <= ub_addr_t'(base_addr);
                count_q     <= row_count;
                row_idx     <= '0;
                err_timeout <= 1'b0;
            end
            if (row_done) begin
                row_idx <= row_idx + 9'd1;
            end
            if (state == WAIT) begin
                if (tmo_cnt != 8'hFF) begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                end
            end else begin
                tmo_cnt <= '0;
            end
            if (tmo_hit && !abort) begin
                err_timeout <= 1'b1;
            end
        end
    end

    row_byte_serializer u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (capture),
        .load_dat  (ub.ub_rd_data),
        .flush     (abort),
        .tx_data   (ub.tx_data),
        .tx_valid  (ub.tx_valid),
        .tx_ready  (ub.tx_ready),
        .last_byte (last_byte)
    );

endmodule

// File: tb/tb_ub_readback_tx.sv
// Directed bench for ub_readback_tx: UB responder, byte/address scoreboards, per-cycle stream checks.
module tb_ub_readback_tx;

    logic       clk = 1'b0;
    logic       rst_n, start, abort;
    logic [8:0] base_addr, row_count;
    logic       busy, done, err_timeout;

    ub_readback_tx_if rb_if ();

    ub_readback_tx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .base_addr   (base_addr),
        .row_count   (row_count),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .err_timeout (err_timeout),
        .ub          (rb_if)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    int req_cnt = 0;
    int done_cnt = 0;
    logic [8:0] exp_addr_q[$];
    logic [7:0] exp_byte_q[$];
    logic [7:0] obs_q[$];
    bit resp_en = 1'b1;
    bit tog_en = 1'b0;
    bit ready_lvl = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model row content: byte i of row a, LSB first on the stream.
    function automatic logic [7:0] byte_of(input logic [8:0] a, input int i);
        byte_of = 8'(i) + 8'(3 * a[7:0]) + (a[8] ? 8'h55 : 8'h00);
    endfunction

    function automatic logic [255:0] row_of(input logic [8:0] a);
        logic [255:0] r;
        for (int i = 0; i < 32; i++) r[8*i +: 8] = byte_of(a, i);
        return r;
    endfunction

    task automatic push_row(input logic [8:0] a, input int nbytes);
        exp_addr_q.push_back(a);
        for (int i = 0; i < nbytes; i++) exp_byte_q.push_back(byte_of(a, i));
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input logic [8:0] b, input logic [8:0] c, input logic ab, output int t0);
        start = 1'b1;
        base_addr = b;
        row_count = c;
        abort = ab;
        t0 = cyc;
        step();
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic wait_done(input int budget, input int t0, output int at);
        at = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done) begin
                at = cyc - t0;
                break;
            end
        end
        chk("done_within_budget", at >= 0, 1);
    endtask

    task automatic queues_empty(input string tag);
        chk({tag, "_addr_q_left"}, exp_addr_q.size(), 0);
        chk({tag, "_byte_q_left"}, exp_byte_q.size(), 0);
    endtask

    // UB model: answers each request with the addressed row two cycles later.
    initial begin : ub_resp
        logic [8:0] a;
        rb_if.ub_rd_valid = 1'b0;
        rb_if.ub_rd_data  = '0;
        forever begin
            @(negedge clk);
            if (rst_n && rb_if.ub_rd_en && resp_en) begin
                a = rb_if.ub_rd_addr;
                @(posedge clk);
                @(posedge clk);
                #1;
                rb_if.ub_rd_valid = 1'b1;
                rb_if.ub_rd_data  = row_of(a);
                @(posedge clk);
                #1;
                rb_if.ub_rd_valid = 1'b0;
            end
        end
    end

    initial begin : ready_drv
        rb_if.tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            rb_if.tx_ready = tog_en ? ~rb_if.tx_ready : ready_lvl;
        end
    end

    initial begin : cmp
        logic       prev_stall;
        logic       prev_en;
        logic [7:0] prev_dat;
        prev_stall = 1'b0;
        prev_en = 1'b0;
        prev_dat = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                prev_en = 1'b0;
            end else begin
                if (rb_if.ub_rd_en) begin
                    req_cnt++;
                    chk("rd_count", rb_if.ub_rd_count, 1);
                    chk("rd_en_one_cycle", prev_en, 0);
                    chk("req_expected", exp_addr_q.size() > 0, 1);
                    if (exp_addr_q.size() > 0) chk("req_addr", rb_if.ub_rd_addr, exp_addr_q.pop_front());
                end
                if (done) done_cnt++;
                if (prev_stall) begin
                    chk("hold_valid", rb_if.tx_valid, 1);
                    chk("hold_data", rb_if.tx_data, prev_dat);
                end
                if (rb_if.tx_valid && rb_if.tx_ready) begin
                    chk("byte_expected", exp_byte_q.size() > 0, 1);
                    if (exp_byte_q.size() > 0) chk("byte_data", rb_if.tx_data, exp_byte_q.pop_front());
                    obs_q.push_back(rb_if.tx_data);
                end
                prev_stall = rb_if.tx_valid && !rb_if.tx_ready && !abort;
                prev_dat   = rb_if.tx_data;
                prev_en    = rb_if.ub_rd_en;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no completion, expected finish before 500000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int t0, at, d, r;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        base_addr = '0;
        row_count = '0;

        // Reset state
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_rd_en", rb_if.ub_rd_en, 0);
        chk("rst_rd_addr", rb_if.ub_rd_addr, 0);
        chk("rst_rd_count", rb_if.ub_rd_count, 0);
        chk("rst_tx_valid", rb_if.tx_valid, 0);
        chk("rst_tx_data", rb_if.tx_data, 0);
        step();
        rst_n = 1'b1;
        step(2);

        // Two rows from 0x005, full-rate sink
        push_row(9'h005, 32);
        push_row(9'h006, 32);
        obs_q.delete();
        d = done_cnt;
        do_start(9'h005, 9'd2, 1'b0, t0);
        @(negedge clk);
        chk("t1_busy_c1", busy, 1);
        chk("t1_rd_en_c1", rb_if.ub_rd_en, 1);
        chk("t1_addr_c1", rb_if.ub_rd_addr, 9'h005);
        wait_done(200, t0, at);
        chk("t1_done_cycle", at, 71);
        chk("t1_err", err_timeout, 0);
        step();
        chk("t1_busy_after", busy, 0);
        chk("t1_done_pulses", done_cnt - d, 1);
        chk("t1_nbytes", obs_q.size(), 64);
        chk("t1_first_byte", obs_q[0], 8'h0F);
        chk("t1_row1_byte0", obs_q[32], 8'h12);
        chk("t1_last_byte", obs_q[63], 8'h31);
        queues_empty("t1");

        // Stalling sink: alternate tx_ready, row 0x000 carries 0x00..0x1F
        push_row(9'h000, 32);
        obs_q.delete();
        tog_en = 1'b1;
        do_start(9'h000, 9'd1, 1'b0, t0);
        wait_done(300, t0, at);
        step();
        tog_en = 1'b0;
        chk("t2_nbytes", obs_q.size(), 32);
        for (int i = 0; i < 32; i++) chk("t2_seq", obs_q[i], i);
        queues_empty("t2");
        step(2);

        // Row field wraps, bank bit sticks
        push_row(9'h1FF, 32);
        push_row(9'h100, 32);
        obs_q.delete();
        do_start(9'h1FF, 9'd2, 1'b0, t0);
        @(negedge clk);
        chk("t3_addr_c1", rb_if.ub_rd_addr, 9'h1FF);
        wait_done(200, t0, at);
        chk("t3_done_cycle", at, 71);
        step();
        chk("t3_row0_byte0", obs_q[0], 8'h52);
        chk("t3_row1_byte0", obs_q[32], 8'h55);
        queues_empty("t3");

        // Read timeout, then the next start clears the flag
        resp_en = 1'b0;
        exp_addr_q.push_back(9'h010);
        do_start(9'h010, 9'd1, 1'b0, t0);
        wait_done(400, t0, at);
        chk("t4_done_cycle", at, 257);
        chk("t4_err_in_done", err_timeout, 1);
        step();
        chk("t4_err_sticky", err_timeout, 1);
        chk("t4_busy_after", busy, 0);
        resp_en = 1'b1;
        push_row(9'h011, 32);
        do_start(9'h011, 9'd1, 1'b0, t0);
        @(negedge clk);
        chk("t4_err_cleared", err_timeout, 0);
        wait_done(100, t0, at);
        chk("t4_retry_done_cycle", at, 36);
        step();
        queues_empty("t4");

        // Abort while byte 10 of row 0 is held
        push_row(9'h020, 10);
        d = done_cnt;
        do_start(9'h020, 9'd2, 1'b0, t0);
        step(13);
        abort = 1'b1;
        ready_lvl = 1'b0;
        @(negedge clk);
        chk("t5_held_valid", rb_if.tx_valid, 1);
        chk("t5_held_byte10", rb_if.tx_data, 8'h6A);
        step();
        abort = 1'b0;
        ready_lvl = 1'b1;
        @(negedge clk);
        chk("t5_valid_dropped", rb_if.tx_valid, 0);
        chk("t5_busy_dropped", busy, 0);
        chk("t5_no_done", done, 0);
        step(20);
        chk("t5_done_count", done_cnt - d, 0);
        queues_empty("t5");
        // start and abort together while idle: start wins
        push_row(9'h030, 32);
        do_start(9'h030, 9'd1, 1'b1, t0);
        wait_done(100, t0, at);
        chk("t5_restart_done_cycle", at, 36);
        step();
        queues_empty("t5b");

        // Zero-length readback
        d = done_cnt;
        r = req_cnt;
        do_start(9'h050, 9'd0, 1'b0, t0);
        @(negedge clk);
        chk("t6_busy_c1", busy, 1);
        chk("t6_done_c1", done, 1);
        chk("t6_rd_en_c1", rb_if.ub_rd_en, 0);
        chk("t6_valid_c1", rb_if.tx_valid, 0);
        step();
        @(negedge clk);
        chk("t6_busy_c2", busy, 0);
        chk("t6_done_c2", done, 0);
        step();
        chk("t6_req_count", req_cnt - r, 0);
        chk("t6_done_count", done_cnt - d, 1);

        // Start while busy is ignored
        push_row(9'h060, 32);
        r = req_cnt;
        do_start(9'h060, 9'd1, 1'b0, t0);
        step(3);
        start = 1'b1;
        base_addr = 9'h070;
        row_count = 9'd1;
        step();
        start = 1'b0;
        wait_done(100, t0, at);
        chk("t6_busy_start_done_cycle", at, 36);
        step(3);
        chk("t6_busy_start_reqs", req_cnt - r, 1);
        queues_empty("t6");

        // Abort coinciding with the final byte transfer
        push_row(9'h080, 32);
        d = done_cnt;
        do_start(9'h080, 9'd1, 1'b0, t0);
        step(34);
        abort = 1'b1;
        @(negedge clk);
        chk("t7_last_valid", rb_if.tx_valid, 1);
        chk("t7_last_byte", rb_if.tx_data, 8'h9F);
        step();
        abort = 1'b0;
        @(negedge clk);
        chk("t7_busy_dropped", busy, 0);
        chk("t7_valid_dropped", rb_if.tx_valid, 0);
        step(5);
        chk("t7_no_done", done_cnt - d, 0);
        queues_empty("t7");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
